// File: rtl/mem_port_arbiter_if.sv
// Request/grant/valid bundle between the core's fetch and load/store ports,
// the shared-memory arbiter and the memory macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ins_req;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_gnt;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_valid;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view
  modport slave (
    input  ins_req, ins_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
    output ins_gnt, ins_valid, ins_rdata, data_gnt, data_valid, data_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester / memory-side view
  modport master (
    output ins_req, ins_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
    input  ins_gnt, ins_valid, ins_rdata, data_gnt, data_valid, data_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port unified memory, fixed-latency access.
// Define MEM_PORT_ARBITER_RR_EN for round-robin ties; otherwise data beats fetch.
//
// state  | meaning
// S_IDLE | sample requests, latch winner's address/we/wdata
// S_BUSY | memory enabled for WAIT_CYC cycles, rdata captured on the last one
// S_RESP | winner's valid pulse, always back to S_IDLE
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              win_data_q, win_data_d;
  logic              pick_data;

  logic              ins_gnt_q, ins_gnt_d;
  logic              ins_valid_q, ins_valid_d;
  logic [DATA_W-1:0] ins_rdata_q, ins_rdata_d;
  logic              data_gnt_q, data_gnt_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

`ifdef MEM_PORT_ARBITER_RR_EN
  // 1 = data port served last; reset value favours data on the first tie
  logic              last_data_q, last_data_d;
  assign pick_data = bus.data_req & (~bus.ins_req | ~last_data_q);
`else
  assign pick_data = bus.data_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_data_d   = win_data_q;
    ins_gnt_d    = 1'b0;
    ins_valid_d  = 1'b0;
    ins_rdata_d  = ins_rdata_q;
    data_gnt_d   = 1'b0;
    data_valid_d = 1'b0;
    data_rdata_d = data_rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef MEM_PORT_ARBITER_RR_EN
    last_data_d  = last_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ins_req || bus.data_req) begin
          state_d     = S_BUSY;
          cnt_d       = CNT_LOAD;
          win_data_d  = pick_data;
          ins_gnt_d   = ~pick_data;
          data_gnt_d  = pick_data;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_data & bus.data_we;
          mem_addr_d  = pick_data ? bus.data_addr : bus.ins_addr;
          mem_wdata_d = pick_data ? bus.data_wdata : '0;
`ifdef MEM_PORT_ARBITER_RR_EN
          last_data_d = pick_data;
`endif
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (win_data_q) begin
            data_valid_d = 1'b1;
            // writes leave the data read register untouched
            if (!mem_we_q) data_rdata_d = bus.mem_rdata;
          end else begin
            ins_valid_d = 1'b1;
            ins_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      win_data_q   <= 1'b0;
      ins_gnt_q    <= 1'b0;
      ins_valid_q  <= 1'b0;
      ins_rdata_q  <= '0;
      data_gnt_q   <= 1'b0;
      data_valid_q <= 1'b0;
      data_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_data_q   <= win_data_d;
      ins_gnt_q    <= ins_gnt_d;
      ins_valid_q  <= ins_valid_d;
      ins_rdata_q  <= ins_rdata_d;
      data_gnt_q   <= data_gnt_d;
      data_valid_q <= data_valid_d;
      data_rdata_q <= data_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MEM_PORT_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (rst) last_data_q <= 1'b0;
    else     last_data_q <= last_data_d;
  end
`endif

  assign bus.ins_gnt    = ins_gnt_q;
  assign bus.ins_valid  = ins_valid_q;
  assign bus.ins_rdata  = ins_rdata_q;
  assign bus.data_gnt   = data_gnt_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;

endmodule
